xhdmiin_wordalign: RTL and testbench
====================================

XHDMIIN_WORDALIGN -- requirements
Module: xhdmiin_wordalign

Interface
REQ-001 SHALL have parameter DW, default 10: width in bits of the input and output words.
REQ-002 SHALL have parameters SYNC0, SYNC1, SYNC2, SYNC3, each [DW-1:0], defaults 10'h354, 10'h0ab, 10'h154, 10'h2ab: the sync/control patterns.
REQ-003 SHALL have parameter SEARCH_WORDS, default 1024: number of valid words examined per candidate offset.
REQ-004 SHALL have parameter MIN_TOKENS, default 16: tokens required within one search window to declare lock.
REQ-005 SHALL have parameter LOSS_WORDS, default 4096: number of consecutive valid words without a token that causes loss of lock.
REQ-006 SHALL have parameter OPT_BITREVERSE, default 1'b0: bit-reverses i_word before alignment.
REQ-007 SHALL have port i_clk, input, 1 bit: pixel clock (the only clock).
REQ-008 SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port i_ce, input, 1 bit: i_word valid this cycle.
REQ-010 SHALL have port i_word, input, DW bits: raw unaligned word from the deserializer.
REQ-011 SHALL have port i_manual_en, input, 1 bit: forces the offset to i_manual_offset.
REQ-012 SHALL have port i_manual_offset, input, $clog2(DW) bits: the forced offset.
REQ-013 SHALL have port o_valid, output, 1 bit: o_word is valid.
REQ-014 SHALL have port o_word, output, DW bits: aligned word.
REQ-015 SHALL have port o_locked, output, 1 bit: alignment is locked.
REQ-016 SHALL have port o_offset, output, $clog2(DW) bits: current bit offset.

Function
REQ-017 SHALL form the history vector h = {w, prev}, where w is i_word (bit-reversed if OPT_BITREVERSE) and prev is the w of the previous i_ce cycle; the candidate word SHALL be h[offset+DW-1:offset].
REQ-018 SHALL update prev, counters and state only on cycles with i_ce=1; cycles with i_ce=0 SHALL hold all state.
REQ-019 SHALL register the candidate word into o_word one cycle after an i_ce cycle, with o_valid=1 in that cycle; when i_ce=0, o_valid SHALL be 0 in the following cycle and o_word SHALL hold its value.
REQ-020 SHALL define a token as a candidate word equal to any of SYNC0 through SYNC3.
REQ-021 SHALL implement the states SEARCH, LOCKED and MANUAL.
REQ-022 In SEARCH, SHALL count valid words (wcnt) and tokens (tcnt, saturating at MIN_TOKENS); a token on the final word SHALL be included in tcnt.
REQ-023 When the SEARCH_WORDS-th word is counted: if tcnt >= MIN_TOKENS, SHALL go to LOCKED; otherwise SHALL set offset to offset+1, wrapping from DW-1 to 0; in both cases wcnt and tcnt SHALL be cleared.
REQ-024 In LOCKED, SHALL count valid words since the last token (mcnt); a token SHALL clear mcnt.
REQ-025 In LOCKED, when mcnt reaches LOSS_WORDS, SHALL go to SEARCH with offset+1 (wrapping) and cleared counters.
REQ-026 o_locked SHALL be 1 exactly while the state is LOCKED, registered, i.e. it changes in the cycle after the transition.
REQ-027 When i_manual_en=1, SHALL enter MANUAL from any state regardless of i_ce, with offset = i_manual_offset, clamped to DW-1 if the value is >= DW.
REQ-028 In MANUAL, SHALL hold counters cleared and hold o_locked=0.
REQ-029 When i_manual_en falls, SHALL enter SEARCH at the current offset.
REQ-030 i_manual_en SHALL take priority over any lock or loss decision in the same cycle.
REQ-031 o_offset SHALL always equal the offset register.
REQ-032 All counter widths SHALL be sized from their parameters so that no counter wraps before its terminal value.

Reset
REQ-033 While i_reset=1, SHALL asynchronously force: state=SEARCH, offset=0, wcnt=tcnt=mcnt=0, prev=0, o_word=0, o_valid=0, o_locked=0, o_offset=0.
REQ-034 Reset asserted mid-search or while LOCKED SHALL discard lock immediately.
REQ-035 After i_reset falls, the first counted word SHALL be the first i_ce cycle following release.

Verification
REQ-036 Scenario: serial stream of repeated 10'h354 shifted by 3 bits, i_ce=1 continuously -> offset steps 0,1,2,3 at 1024-word intervals; o_locked=1 after the 4096th word; o_word=10'h354 thereafter.
REQ-037 Scenario: locked at offset 3, then a stream with no tokens for 4096 words -> o_locked falls the cycle after the 4096th word; o_offset=4.
REQ-038 Scenario: a stream without tokens, i_ce=1 -> o_offset wraps 9 -> 0 after 10240 words; o_locked stays 0.
REQ-039 Scenario: i_ce toggling 1,0,1,0 -> o_valid pattern 0,1,0,1; counters advance only on i_ce=1; lock is reached after exactly 1024 i_ce cycles per offset.
REQ-040 Scenario: i_manual_en=1 with i_manual_offset=12, DW=10 -> o_offset=9, o_locked=0; after release, search resumes from 9.
REQ-041 Scenario: i_reset pulsed for 1 cycle while LOCKED -> all outputs 0 immediately; relock takes the full search sequence.

Source files
------------

// File: rtl/xhdmiin_wordalign.sv
// Word aligner for a deserialized TMDS stream. It scans each bit offset for sync
// tokens, locks when enough appear in one window, and drops lock when they stop.
module xhdmiin_wordalign #(
  parameter int              DW             = 10,
  parameter logic [DW-1:0]   SYNC0          = 10'h354,
  parameter logic [DW-1:0]   SYNC1          = 10'h0ab,
  parameter logic [DW-1:0]   SYNC2          = 10'h154,
  parameter logic [DW-1:0]   SYNC3          = 10'h2ab,
  parameter int              SEARCH_WORDS   = 1024,
  parameter int              MIN_TOKENS     = 16,
  parameter int              LOSS_WORDS     = 4096,
  parameter bit              OPT_BITREVERSE = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic [DW-1:0]         i_word,
  input  logic                  i_manual_en,
  input  logic [$clog2(DW)-1:0] i_manual_offset,
  output logic                  o_valid,
  output logic [DW-1:0]         o_word,
  output logic                  o_locked,
  output logic [$clog2(DW)-1:0] o_offset
);

  localparam int OW  = $clog2(DW);
  localparam int WCW = $clog2(SEARCH_WORDS + 1);
  localparam int TCW = $clog2(MIN_TOKENS + 1);
  localparam int MCW = $clog2(LOSS_WORDS + 1);

  localparam logic [WCW-1:0] W_LAST  = WCW'(SEARCH_WORDS - 1);
  localparam logic [TCW-1:0] T_MIN   = TCW'(MIN_TOKENS);
  localparam logic [MCW-1:0] M_LAST  = MCW'(LOSS_WORDS - 1);
  localparam logic [OW-1:0]  OFF_MAX = OW'(DW - 1);
  localparam logic [OW:0]    DW_EXT  = (OW + 1)'(DW);

  typedef enum logic [1:0] {ST_SEARCH, ST_LOCKED, ST_MANUAL} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   offset_q, offset_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;
  logic [MCW-1:0]  mcnt_q, mcnt_d;
  logic [DW-1:0]   prev_q, prev_d;
  logic [DW-1:0]   word_q, word_d;
  logic            valid_q, valid_d;
  logic            locked_q, locked_d;

  logic [DW-1:0]   w;
  logic [2*DW-1:0] h;
  logic [DW-1:0]   cand;
  logic            tok;
  logic [OW-1:0]   off_inc;
  logic [TCW-1:0]  tcnt_sat;

  always_comb begin
    w = i_word;
    if (OPT_BITREVERSE) begin
      for (int i = 0; i < DW; i++) w[i] = i_word[DW-1-i];
    end
  end

  assign h        = {w, prev_q};
  assign cand     = h[offset_q +: DW];
  assign tok      = (cand == SYNC0) || (cand == SYNC1) || (cand == SYNC2) || (cand == SYNC3);
  assign off_inc  = (offset_q == OFF_MAX) ? '0 : offset_q + OW'(1);
  assign tcnt_sat = (tok && (tcnt_q != T_MIN)) ? tcnt_q + TCW'(1) : tcnt_q;

  // Manual override beats every lock/loss decision; leaving manual restarts the search in place.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    mcnt_d   = mcnt_q;
    prev_d   = prev_q;
    word_d   = word_q;
    valid_d  = i_ce;
    if (i_ce) begin
      prev_d = w;
      word_d = cand;
    end
    if (i_manual_en) begin
      state_d  = ST_MANUAL;
      offset_d = ({1'b0, i_manual_offset} >= DW_EXT) ? OFF_MAX : i_manual_offset;
      wcnt_d   = '0;
      tcnt_d   = '0;
      mcnt_d   = '0;
    end else if (state_q == ST_MANUAL) begin
      state_d = ST_SEARCH;
      wcnt_d  = '0;
      tcnt_d  = '0;
      mcnt_d  = '0;
    end else if (i_ce) begin
      case (state_q)
        ST_SEARCH: begin
          if (wcnt_q == W_LAST) begin
            if (tcnt_sat >= T_MIN) state_d = ST_LOCKED;
            else                   offset_d = off_inc;
            wcnt_d = '0;
            tcnt_d = '0;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
            tcnt_d = tcnt_sat;
          end
        end
        ST_LOCKED: begin
          if (tok) begin
            mcnt_d = '0;
          end else if (mcnt_q == M_LAST) begin
            state_d  = ST_SEARCH;
            offset_d = off_inc;
            mcnt_d   = '0;
          end else begin
            mcnt_d = mcnt_q + MCW'(1);
          end
        end
        default: ;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_SEARCH;
      offset_q <= '0;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
      mcnt_q   <= '0;
      prev_q   <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      mcnt_q   <= mcnt_d;
      prev_q   <= prev_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_word   = word_q;
  assign o_locked = locked_q;
  assign o_offset = offset_q;

endmodule

// File: tb/tb_xhdmiin_wordalign.sv
// Self-checking bench for xhdmiin_wordalign: scenario tasks plus a word-level
// reference model that predicts every output after every clock.
module tb_xhdmiin_wordalign;

  localparam int DW = 10;
  localparam int OW = 4;
  localparam int SEARCH_WORDS = 1024;
  localparam int MIN_TOKENS = 16;
  localparam int LOSS_WORDS = 4096;
  localparam int MD_SEARCH = 0, MD_LOCKED = 1, MD_MANUAL = 2;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_ce = 1'b0;
  logic [DW-1:0] i_word = '0;
  logic          i_manual_en = 1'b0;
  logic [OW-1:0] i_manual_offset = '0;
  logic          o_valid;
  logic [DW-1:0] o_word;
  logic          o_locked;
  logic [OW-1:0] o_offset;

  xhdmiin_wordalign dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_word(i_word),
    .i_manual_en(i_manual_en), .i_manual_offset(i_manual_offset),
    .o_valid(o_valid), .o_word(o_word), .o_locked(o_locked), .o_offset(o_offset)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;

  // Reference model state: plain integers following the alignment rules word by word.
  int m_mode, m_off, m_words, m_tokens, m_miss, m_prev;
  logic          exp_valid, exp_locked;
  logic [DW-1:0] exp_word;
  logic [OW-1:0] exp_off;
  logic [DW-1:0] w_shift;

  function automatic void model_reset();
    m_mode = MD_SEARCH; m_off = 0; m_words = 0; m_tokens = 0; m_miss = 0; m_prev = 0;
    exp_valid = 1'b0; exp_locked = 1'b0; exp_word = '0; exp_off = '0;
  endfunction

  function automatic void model_step(input bit ce, input int word, input bit men, input int moff);
    int  cand;
    bit  tok;
    cand = (((word << DW) | m_prev) >> m_off) & ((1 << DW) - 1);
    tok  = (cand == 'h354) || (cand == 'h0ab) || (cand == 'h154) || (cand == 'h2ab);
    exp_valid = ce;
    if (ce) begin
      exp_word = DW'(cand);
      m_prev   = word;
    end
    if (men) begin
      m_mode = MD_MANUAL;
      m_off  = (moff >= DW) ? DW - 1 : moff;
      m_words = 0; m_tokens = 0; m_miss = 0;
    end else if (m_mode == MD_MANUAL) begin
      m_mode = MD_SEARCH;
      m_words = 0; m_tokens = 0; m_miss = 0;
    end else if (ce && m_mode == MD_SEARCH) begin
      m_words++;
      if (tok && m_tokens < MIN_TOKENS) m_tokens++;
      if (m_words == SEARCH_WORDS) begin
        if (m_tokens >= MIN_TOKENS) m_mode = MD_LOCKED;
        else m_off = (m_off + 1) % DW;
        m_words = 0; m_tokens = 0;
      end
    end else if (ce && m_mode == MD_LOCKED) begin
      m_miss = tok ? 0 : m_miss + 1;
      if (m_miss == LOSS_WORDS) begin
        m_mode = MD_SEARCH;
        m_off  = (m_off + 1) % DW;
        m_miss = 0;
      end
    end
    exp_locked = (m_mode == MD_LOCKED);
    exp_off    = OW'(m_off);
  endfunction

  // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic tick(input bit ce, input logic [DW-1:0] word, input bit men, input logic [OW-1:0] moff);
    i_ce = ce; i_word = word; i_manual_en = men; i_manual_offset = moff;
    model_step(ce, int'(word), men, int'(moff));
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_ce = 1'b0; i_word = '0; i_manual_en = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({o_valid, o_locked, o_offset, o_word} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got v=%0b l=%0b off=%0d w=%h want all zero", o_valid, o_locked, o_offset, o_word);
    end
    do_reset();
    tick(1'b1, 10'h3ff, 1'b0, '0);
    total++;
    if ({o_valid, o_locked, o_offset, o_word} !== {exp_valid, exp_locked, exp_off, exp_word}) begin
      bad++;
      $display("[TB] FAIL first_word: got v=%0b l=%0b off=%0d w=%h want v=%0b l=%0b off=%0d w=%h",
               o_valid, o_locked, o_offset, o_word, exp_valid, exp_locked, exp_off, exp_word);
    end
  endtask

  task automatic test_search_lock();
    int want_off;
    do_reset();
    for (int k = 1; k <= 4096 + 16; k++) begin
      tick(1'b1, w_shift, 1'b0, '0);
      total++;
      if ({o_valid, o_locked, o_offset, o_word} !== {exp_valid, exp_locked, exp_off, exp_word}) begin
        bad++;
        $display("[TB] FAIL lock_model k=%0d: got v=%0b l=%0b off=%0d w=%h want v=%0b l=%0b off=%0d w=%h",
                 k, o_valid, o_locked, o_offset, o_word, exp_valid, exp_locked, exp_off, exp_word);
      end
      want_off = (k / 1024 > 3) ? 3 : k / 1024;
      total++;
      if ({o_locked, o_offset} !== {k >= 4096, OW'(want_off)}) begin
        bad++;
        $display("[TB] FAIL lock_progress k=%0d: got l=%0b off=%0d want l=%0b off=%0d", k, o_locked, o_offset, k >= 4096, want_off);
      end
      if (k > 4096) begin
        total++;
        if (o_word !== 10'h354) begin
          bad++;
          $display("[TB] FAIL locked_word k=%0d: got %h want 354", k, o_word);
        end
      end
    end
  endtask

  task automatic test_loss();
    for (int j = 1; j <= 4096 + 4; j++) begin
      tick(1'b1, '0, 1'b0, '0);
      total++;
      if ({o_valid, o_locked, o_offset, o_word} !== {exp_valid, exp_locked, exp_off, exp_word}) begin
        bad++;
        $display("[TB] FAIL loss_model j=%0d: got v=%0b l=%0b off=%0d w=%h want v=%0b l=%0b off=%0d w=%h",
                 j, o_valid, o_locked, o_offset, o_word, exp_valid, exp_locked, exp_off, exp_word);
      end
      total++;
      if ({o_locked, o_offset} !== {j < 4096, (j < 4096) ? 4'd3 : 4'd4}) begin
        bad++;
        $display("[TB] FAIL loss_point j=%0d: got l=%0b off=%0d want l=%0b off=%0d", j, o_locked, o_offset, j < 4096, (j < 4096) ? 3 : 4);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 1; k <= 10240; k++) begin
      tick(1'b1, '0, 1'b0, '0);
      if (k % 256 == 0) begin
        total++;
        if ({o_locked, o_offset} !== {1'b0, OW'((k / 1024) % 10)}) begin
          bad++;
          $display("[TB] FAIL wrap k=%0d: got l=%0b off=%0d want l=0 off=%0d", k, o_locked, o_offset, (k / 1024) % 10);
        end
      end
    end
  endtask

  task automatic test_ce_toggle();
    int n;
    do_reset();
    n = 0;
    for (int c = 0; c < 8192; c++) begin
      tick(c % 2 == 0, w_shift, 1'b0, '0);
      if (c % 2 == 0) n++;
      total++;
      if ({o_valid, o_locked, o_offset, o_word} !== {exp_valid, exp_locked, exp_off, exp_word}) begin
        bad++;
        $display("[TB] FAIL ce_model c=%0d: got v=%0b l=%0b off=%0d w=%h want v=%0b l=%0b off=%0d w=%h",
                 c, o_valid, o_locked, o_offset, o_word, exp_valid, exp_locked, exp_off, exp_word);
      end
      total++;
      if ({o_valid, o_locked, o_offset} !== {c % 2 == 0, n >= 4096, OW'((n / 1024 > 3) ? 3 : n / 1024)}) begin
        bad++;
        $display("[TB] FAIL ce_pattern c=%0d: got v=%0b l=%0b off=%0d want v=%0b l=%0b", c, o_valid, o_locked, o_offset, c % 2 == 0, n >= 4096);
      end
    end
  endtask

  task automatic test_reset_while_locked();
    i_ce = 1'b1; i_word = w_shift;
    i_reset = 1'b1;
    #2;
    total++;
    if ({o_valid, o_locked, o_offset, o_word} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset: got v=%0b l=%0b off=%0d w=%h want all zero", o_valid, o_locked, o_offset, o_word);
    end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 4097; k++) begin
      tick(1'b1, w_shift, 1'b0, '0);
      total++;
      if ({o_valid, o_locked, o_offset, o_word} !== {exp_valid, exp_locked, exp_off, exp_word} || o_locked !== (k >= 4096)) begin
        bad++;
        $display("[TB] FAIL relock k=%0d: got v=%0b l=%0b off=%0d w=%h want v=%0b l=%0b off=%0d w=%h",
                 k, o_valid, o_locked, o_offset, o_word, exp_valid, k >= 4096, exp_off, exp_word);
      end
    end
  endtask

  task automatic test_manual();
    do_reset();
    for (int k = 1; k < 4096; k++) tick(1'b1, w_shift, 1'b0, '0);
    tick(1'b1, w_shift, 1'b1, 4'd5);
    total++;
    if ({o_locked, o_offset} !== {1'b0, 4'd5}) begin
      bad++;
      $display("[TB] FAIL manual_priority: got l=%0b off=%0d want l=0 off=5", o_locked, o_offset);
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'($urandom_range(0, 1)), DW'($urandom), 1'b1, 4'd12);
      total++;
      if ({o_locked, o_offset, o_valid, o_word} !== {1'b0, 4'd9, exp_valid, exp_word}) begin
        bad++;
        $display("[TB] FAIL manual_clamp k=%0d: got l=%0b off=%0d v=%0b w=%h want l=0 off=9 v=%0b w=%h",
                 k, o_locked, o_offset, o_valid, o_word, exp_valid, exp_word);
      end
    end
    tick(1'b0, '0, 1'b0, '0);
    for (int k = 1; k <= 1030; k++) begin
      tick(1'b1, '0, 1'b0, '0);
      total++;
      if ({o_locked, o_offset} !== {1'b0, (k < 1024) ? 4'd9 : 4'd0}) begin
        bad++;
        $display("[TB] FAIL manual_resume k=%0d: got l=%0b off=%0d want l=0 off=%0d", k, o_locked, o_offset, (k < 1024) ? 9 : 0);
      end
    end
  endtask

  task automatic test_random();
    bit ce, men, last_men;
    logic [DW-1:0] wd;
    do_reset();
    last_men = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      men = ($urandom_range(0, 199) == 0) || (last_men && $urandom_range(0, 3) != 0);
      ce  = ($urandom_range(0, 3) != 0) && !(last_men && !men);
      wd  = ($urandom_range(0, 1) == 0) ? w_shift : DW'($urandom);
      tick(ce, wd, men, OW'($urandom_range(0, 15)));
      last_men = men;
      total++;
      if ({o_valid, o_locked, o_offset, o_word} !== {exp_valid, exp_locked, exp_off, exp_word}) begin
        bad++;
        $display("[TB] FAIL random c=%0d: got v=%0b l=%0b off=%0d w=%h want v=%0b l=%0b off=%0d w=%h",
                 c, o_valid, o_locked, o_offset, o_word, exp_valid, exp_locked, exp_off, exp_word);
      end
    end
  endtask

  initial begin
    int p;
    p = 'h354;
    w_shift = DW'(((p << 3) | (p >> 7)) & 'h3ff);
    model_reset();
    test_reset();
    test_search_lock();
    test_loss();
    test_wrap();
    test_ce_toggle();
    test_reset_while_locked();
    test_manual();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
